// File: rtl/irrigation_scheduler.sv
// Tank-fed irrigation controller: keeps the tank filled, then waters by sprinkler or
// drip while the soil is dry, with a cooldown after each run and a level-sensor fault trap.
module irrigation_scheduler #(
  parameter int unsigned TICK_DIV     = 50000000,
  parameter int unsigned IRR_TIME     = 30,
  parameter int unsigned FILL_TIMEOUT = 60,
  parameter int unsigned COOL_TIME    = 10
) (
  input  logic       clk,
  input  logic       rest,
  input  logic       H,
  input  logic       M,
  input  logic       L,
  input  logic       Us,
  input  logic       Ua,
  input  logic       T,
  input  logic       switch,
  output logic       Vs,
  output logic       Bs,
  output logic       Ve,
  output logic [2:0] state,
  output logic       fault,
  output logic [7:0] remaining
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TW = 8;
  localparam int unsigned NW = 7;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FILL     = 3'd1,
    S_IRRIGATE = 3'd2,
    S_COOLDOWN = 3'd3,
    S_FAULT    = 3'd4
  } state_t;

  logic [NW-1:0] r_sync1;
  logic [NW-1:0] r_sync2;
  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [TW-1:0] r_timer;
  logic          r_mode_drip;
  logic          r_vs;
  logic          r_bs;
  logic          r_ve;
  logic          r_fault;
  logic [TW-1:0] r_remaining;

  logic          w_h, w_m, w_l, w_us, w_ua, w_t, w_sw;
  logic          w_lvl_bad;
  logic          w_tick;
  logic          w_expire;
  logic          w_entry;
  logic          w_active;
  state_t        w_next;
  logic [TW-1:0] w_timer_nxt;
  logic [PW-1:0] w_presc_nxt;
  logic          w_mode_nxt;

  assign {w_h, w_m, w_l, w_us, w_ua, w_t, w_sw} = r_sync2;

  // A wet mark above a dry one means a stuck or broken sensor
  assign w_lvl_bad = (w_h & ~w_m) | (w_m & ~w_l);
  assign w_tick    = (r_presc == PW'(TICK_DIV - 1));
  // Timer is about to hit zero on this tick (or already sits there)
  assign w_expire  = (r_timer == '0) | (w_tick & (r_timer == TW'(1)));

  // Next-state, timer, prescaler and mode-latch decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_m)               w_next = S_FILL;
        else if (w_sw && w_us)  w_next = S_IRRIGATE;
      end
      S_FILL: begin
        if (w_h)                w_next = S_IDLE;
        else if (w_expire)      w_next = S_FAULT;
      end
      S_IRRIGATE: begin
        if (w_expire || !w_us || !w_sw || !w_l) w_next = S_COOLDOWN;
      end
      S_COOLDOWN: begin
        if (w_expire)           w_next = S_IDLE;
      end
      S_FAULT: begin
        if (!w_sw)              w_next = S_IDLE;
      end
      default:                  w_next = S_IDLE;
    endcase
    if (w_lvl_bad) w_next = S_FAULT;

    w_entry = (w_next != r_state);

    w_timer_nxt = r_timer;
    if (w_entry) begin
      case (w_next)
        S_FILL:     w_timer_nxt = TW'(FILL_TIMEOUT);
        S_IRRIGATE: w_timer_nxt = TW'(IRR_TIME);
        S_COOLDOWN: w_timer_nxt = TW'(COOL_TIME);
        default:    w_timer_nxt = '0;
      endcase
    end else if (w_tick && (r_timer != '0)) begin
      w_timer_nxt = r_timer - TW'(1);
    end

    w_presc_nxt = (w_entry || w_tick) ? '0 : r_presc + PW'(1);

    w_mode_nxt = r_mode_drip;
    if ((r_state == S_IDLE) && (w_next == S_IRRIGATE)) w_mode_nxt = w_t | w_ua;

    w_active = (w_next == S_FILL) || (w_next == S_IRRIGATE) || (w_next == S_COOLDOWN);
  end

  // Synchronizers, state register and outputs decoded from the next state
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_timer     <= '0;
      r_mode_drip <= 1'b0;
      r_vs        <= 1'b0;
      r_bs        <= 1'b0;
      r_ve        <= 1'b0;
      r_fault     <= 1'b0;
      r_remaining <= '0;
    end else begin
      r_sync1     <= {H, M, L, Us, Ua, T, switch};
      r_sync2     <= r_sync1;
      r_state     <= w_next;
      r_presc     <= w_presc_nxt;
      r_timer     <= w_timer_nxt;
      r_mode_drip <= w_mode_nxt;
      r_vs        <= (w_next == S_IRRIGATE) & ~w_mode_nxt;
      r_bs        <= (w_next == S_IRRIGATE) &  w_mode_nxt;
      r_ve        <= (w_next == S_FILL);
      r_fault     <= (w_next == S_FAULT);
      r_remaining <= w_active ? w_timer_nxt : '0;
    end
  end

  assign Vs        = r_vs;
  assign Bs        = r_bs;
  assign Ve        = r_ve;
  assign state     = r_state;
  assign fault     = r_fault;
  assign remaining = r_remaining;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Scoreboard bench for irrigation_scheduler: stimulus queues hand-computed expected
// outputs tagged with a cycle number; a monitor pops and compares them when due.
module tb_irrigation_scheduler;

  localparam int unsigned TICK_DIV     = 4;
  localparam int unsigned IRR_TIME     = 5;
  localparam int unsigned FILL_TIMEOUT = 6;
  localparam int unsigned COOL_TIME    = 3;

  logic       clk  = 1'b0;
  logic       rest = 1'b0;
  logic       H = 1'b1, M = 1'b1, L = 1'b1;
  logic       Us = 1'b0, Ua = 1'b0, T = 1'b0, sw = 1'b0;
  logic       Vs, Bs, Ve, fault;
  logic [2:0] state;
  logic [7:0] remaining;

  int cyc = 0;
  int n_vec = 0;
  int n_miss = 0;

  typedef struct {
    int         cyc;
    bit         now;
    string      name;
    logic [2:0] st;
    logic       vs;
    logic       bs;
    logic       ve;
    logic       flt;
    logic [7:0] rem;
  } exp_t;

  exp_t sb[$];
  event chk_now;

  irrigation_scheduler #(
    .TICK_DIV    (TICK_DIV),
    .IRR_TIME    (IRR_TIME),
    .FILL_TIMEOUT(FILL_TIMEOUT),
    .COOL_TIME   (COOL_TIME)
  ) dut (
    .clk      (clk),
    .rest     (rest),
    .H        (H),
    .M        (M),
    .L        (L),
    .Us       (Us),
    .Ua       (Ua),
    .T        (T),
    .switch   (sw),
    .Vs       (Vs),
    .Bs       (Bs),
    .Ve       (Ve),
    .state    (state),
    .fault    (fault),
    .remaining(remaining)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void sb_insert(input exp_t e);
    int idx;
    idx = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > e.cyc) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endfunction

  // Expect a given output tuple dc posedges from now
  task automatic expect_at(input int dc, input string nm, input logic [2:0] st,
                           input logic vs, input logic bs, input logic ve,
                           input logic flt, input logic [7:0] rem);
    exp_t e;
    e.cyc = cyc + dc; e.now = 1'b0; e.name = nm;
    e.st = st; e.vs = vs; e.bs = bs; e.ve = ve; e.flt = flt; e.rem = rem;
    sb_insert(e);
  endtask

  // Expect a tuple immediately, between clock edges
  task automatic push_now(input string nm, input logic [2:0] st, input logic vs,
                          input logic bs, input logic ve, input logic flt,
                          input logic [7:0] rem);
    exp_t e;
    e.cyc = cyc; e.now = 1'b1; e.name = nm;
    e.st = st; e.vs = vs; e.bs = bs; e.ve = ve; e.flt = flt; e.rem = rem;
    sb_insert(e);
    -> chk_now;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor: clocked items on the falling edge, immediate items on chk_now
  initial begin : monitor
    forever begin
      @(negedge clk or chk_now);
      while (sb.size() > 0 && (clk ? sb[0].now : (sb[0].cyc <= cyc))) begin
        exp_t e;
        e = sb.pop_front();
        n_vec++;
        if (!e.now && e.cyc != cyc) begin
          n_miss++;
          $display("FAIL %s: checked late at cycle %0d, due at cycle %0d", e.name, cyc, e.cyc);
        end else if ({state, Vs, Bs, Ve, fault, remaining} !==
                     {e.st, e.vs, e.bs, e.ve, e.flt, e.rem}) begin
          n_miss++;
          $display("FAIL %s @cyc %0d: got st=%0d Vs=%b Bs=%b Ve=%b fault=%b rem=%0d, want st=%0d Vs=%b Bs=%b Ve=%b fault=%b rem=%0d",
                   e.name, cyc, state, Vs, Bs, Ve, fault, remaining,
                   e.st, e.vs, e.bs, e.ve, e.flt, e.rem);
        end
      end
    end
  end

  // Reset with a full tank; cleared synchronizers cause a brief FILL visit
  task automatic do_reset();
    wait_cyc(1);
    rest = 1'b0; H = 1'b1; M = 1'b1; L = 1'b1; Us = 1'b0; Ua = 1'b0; T = 1'b0; sw = 1'b0;
    #1 push_now("in_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    wait_cyc(1);
    rest = 1'b1;
    expect_at(1, "rst_fill", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd6);
    expect_at(3, "rst_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    wait_cyc(5);
  endtask

  initial begin : stimulus
    // Sprinkler run, full countdown, cooldown, idle
    do_reset();
    sw = 1'b1; Us = 1'b1;
    expect_at(2,  "spr_pre",   3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    expect_at(3,  "spr_on",    3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
    expect_at(6,  "spr_r5",    3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
    expect_at(7,  "spr_r4",    3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4);
    expect_at(11, "spr_r3",    3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
    expect_at(15, "spr_r2",    3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    expect_at(19, "spr_r1",    3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    expect_at(22, "spr_last",  3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    expect_at(23, "cool_in",   3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
    expect_at(27, "cool_r2",   3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
    expect_at(34, "cool_r1",   3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    expect_at(35, "cool_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    expect_at(37, "idle_hold", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    wait_cyc(30); sw = 1'b0;
    wait_cyc(8);

    // Drip mode latched on entry, held after T drops
    do_reset();
    T = 1'b1; sw = 1'b1; Us = 1'b1;
    expect_at(3, "drip_on", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5);
    wait_cyc(8); T = 1'b0;
    expect_at(4,  "drip_hold", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
    expect_at(14, "drip_last", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    expect_at(15, "drip_cool", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
    wait_cyc(22); sw = 1'b0;
    wait_cyc(8);

    // Fill completes when the tank reaches the high mark
    do_reset();
    H = 1'b0; M = 1'b0;
    expect_at(3, "fill_on", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd6);
    expect_at(7, "fill_r5", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5);
    wait_cyc(15); H = 1'b1; M = 1'b1;
    expect_at(2, "fill_r3",   3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
    expect_at(3, "fill_done", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    wait_cyc(6);

    // Fill timeout to FAULT, held while switch=1, released by switch=0
    do_reset();
    H = 1'b0; M = 1'b0; sw = 1'b1;
    expect_at(3,  "to_fill",   3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd6);
    expect_at(26, "to_r1",     3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
    expect_at(27, "to_fault",  3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    expect_at(30, "to_hold",   3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    wait_cyc(30); sw = 1'b0;
    expect_at(3, "fault_clr", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    expect_at(4, "refill",    3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd6);
    wait_cyc(6);

    // Soil turns wet after the second tick
    do_reset();
    sw = 1'b1; Us = 1'b1;
    expect_at(3, "us_on", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
    wait_cyc(11); Us = 1'b0;
    expect_at(2, "us_pre",  3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
    expect_at(3, "us_cool", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
    wait_cyc(4); sw = 1'b0;
    expect_at(10, "us_cool1", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    expect_at(11, "us_idle",  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    wait_cyc(14);

    // Invalid level forces FAULT mid-run; needs valid level and switch=0 to leave
    do_reset();
    sw = 1'b1; Us = 1'b1;
    expect_at(3, "lv_on", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
    wait_cyc(5); H = 1'b1; M = 1'b0;
    expect_at(3, "lvl_fault", 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    wait_cyc(4); M = 1'b1;
    expect_at(6, "fault_sw1", 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    wait_cyc(7); sw = 1'b0;
    expect_at(3, "fault_exit", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    expect_at(5, "idle_after", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    wait_cyc(7); H = 1'b0; L = 1'b0;
    expect_at(3, "ml_fault", 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    wait_cyc(5);

    // Sub-cycle reset pulse during irrigation
    do_reset();
    sw = 1'b1; Us = 1'b1;
    expect_at(3, "ar_on",  3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
    expect_at(6, "ar_r5",  3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
    wait_cyc(7);
    rest = 1'b0;
    #1 push_now("async_rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    #1 rest = 1'b1;
    expect_at(1, "ar_fill", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd6);
    expect_at(3, "ar_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    expect_at(4, "ar_irr",  3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);
    wait_cyc(6);
    sw = 1'b0;

    // Drain any outstanding expectations within a bounded window
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      n_miss++;
      $display("FAIL %s: never checked, due at cycle %0d, now cycle %0d", e.name, e.cyc, cyc);
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, limit 20000", cyc);
    $fatal(1);
  end

endmodule

// File: doc/irrigation_scheduler.md
IRRIGATION_SCHEDULER -- requirements
Module: irrigation_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, clock cycles per 1 s tick.
REQ-002 SHALL have parameter IRR_TIME, default 30, irrigation duration in ticks, range 1..255.
REQ-003 SHALL have parameter FILL_TIMEOUT, default 60, maximum fill duration in ticks, range 1..255.
REQ-004 SHALL have parameter COOL_TIME, default 10, idle time after irrigation in ticks, range 1..255.
REQ-005 SHALL have port clk, input, 1 bit: single system clock, rising edge.
REQ-006 SHALL have port rest, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have ports H, M, L, input, 1 bit each: tank level sensors, 1 = water present at high, medium or low mark.
REQ-008 SHALL have port Us, input, 1 bit: 1 = soil dry, irrigation needed.
REQ-009 SHALL have port Ua, input, 1 bit: 1 = air dry.
REQ-010 SHALL have port T, input, 1 bit: 1 = high temperature.
REQ-011 SHALL have port switch, input, 1 bit: 1 = irrigation enabled by operator.
REQ-012 SHALL have ports Vs, Bs, Ve, output, 1 bit each: sprinkler valve, drip pump and tank inlet valve; 1 = on.
REQ-013 SHALL have port state, output, 3 bits: encoded FSM state.
REQ-014 SHALL have port fault, output, 1 bit: 1 while in FAULT.
REQ-015 SHALL have port remaining, output, 8 bits: ticks left on the active timer.

Function
REQ-016 SHALL pass H, M, L, Us, Ua, T and switch through 2-flop synchronizers; all logic SHALL use only the synchronized values.
REQ-017 SHALL implement states IDLE=0, FILL=1, IRRIGATE=2, COOLDOWN=3, FAULT=4; codes 5..7 SHALL go to IDLE on the next clock.
REQ-018 SHALL treat the level as invalid when (H & ~M) | (M & ~L); an invalid level in any state SHALL force FAULT, with priority over all other transitions.
REQ-019 SHALL run a prescaler counting 0..TICK_DIV-1 that emits a 1-cycle tick at TICK_DIV-1 and clears to 0 on every state entry.
REQ-020 SHALL reload the 8-bit timer on state entry (FILL: FILL_TIMEOUT, IRRIGATE: IRR_TIME, COOLDOWN: COOL_TIME, others: 0) and decrement it on each tick, saturating at 0.
REQ-021 IDLE: if M=0, SHALL go to FILL; else if switch=1 and Us=1, SHALL go to IRRIGATE; otherwise SHALL stay in IDLE.
REQ-022 On IDLE->IRRIGATE SHALL latch mode: drip (Bs) if T=1 or Ua=1, else sprinkler (Vs); the mode SHALL be held for the whole IRRIGATE visit.
REQ-023 FILL: SHALL go to IDLE when H=1, and to FAULT if the timer reaches 0 with H=0; H=1 SHALL win when both happen in the same cycle.
REQ-024 IRRIGATE: SHALL go to COOLDOWN when the timer reaches 0, Us=0, switch=0 or L=0, whichever occurs first.
REQ-025 COOLDOWN: SHALL go to IDLE when the timer reaches 0, and SHALL ignore Us and switch.
REQ-026 FAULT: SHALL go to IDLE only when the level is valid and switch=0.
REQ-027 Outputs SHALL be registered and decoded from the next state: Ve=1 only in FILL; Vs or Bs=1 (per latched mode) only in IRRIGATE; Vs and Bs SHALL never both be 1; Ve SHALL never be 1 together with Vs or Bs.
REQ-028 remaining SHALL equal the timer in FILL, IRRIGATE and COOLDOWN, and SHALL be 0 in IDLE and FAULT.
REQ-029 Latency from a pin change to an output change SHALL be 3 clk cycles: 2 for synchronization, 1 for the state register.

Reset
REQ-030 While rest=0, SHALL immediately clear Vs, Bs, Ve, fault, remaining, the timer, the prescaler, the latched mode and the synchronizers, and set state to IDLE.
REQ-031 SHALL resume from IDLE on the first rising clk edge after rest goes high; a reset asserted mid-IRRIGATE or mid-FILL SHALL turn off the actuators with no clock edge required.

Verification (TICK_DIV=4, IRR_TIME=5, FILL_TIMEOUT=6, COOL_TIME=3)
REQ-032 H=M=L=1, switch=1, Us=1, T=0, Ua=0 -> Vs=1 3 cycles later; remaining counts 5..0 every 4 cycles; then COOLDOWN for 12 cycles; then IDLE.
REQ-033 As REQ-032 but T=1, with T dropping to 0 mid-run -> Bs=1 for the whole run and Vs stays 0.
REQ-034 L=1, M=0, H=0 -> Ve=1; raising H=M=1 at tick 3 -> Ve=0 and IDLE; with H held at 0 -> FAULT after 24 cycles and fault=1.
REQ-035 In IRRIGATE, set Us=0 at tick 2 -> Vs=0 3 cycles later, state=3, remaining=3.
REQ-036 H=1, M=0 in any state -> FAULT and all actuators off; valid level with switch=1 -> stays in FAULT; then switch=0 -> IDLE.
REQ-037 Pulse rest low for less than 1 clk period during IRRIGATE -> Vs=0 asynchronously and state=0.
